// File: rtl/sensor_alarm_ctrl.sv
// N-channel sensor alarm: lowest-index sensor is debounced over DEBOUNCE samples,
// then drives a one-hot buzzer for HOLD cycles (or until ack when latched).
module sensor_alarm_ctrl #(
    parameter int N_CH     = 4,
    parameter int DEBOUNCE = 7,
    parameter int HOLD     = 31,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] sensor,
    input  logic            latch_mode,
    input  logic            ack,
    input  logic            clr_hits,
    output logic [N_CH-1:0] buzzer,
    output logic [CH_W-1:0] alarm_ch,
    output logic            busy,
    output logic [N_CH-1:0] hit
);

    localparam int DBC_W  = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(HOLD + 1);
    localparam logic [DBC_W-1:0]  DBC_MAX  = DBC_W'(DEBOUNCE);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUAL  = 2'd1,
        ALARM = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [CH_W-1:0]   cand, cand_nx;
    logic [DBC_W-1:0]  dbc, dbc_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [N_CH-1:0]   buzzer_nx, hit_nx;
    logic              latched, latched_nx;
    logic [CH_W-1:0]   win;
    logic              none;
    logic              fire;

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [N_CH-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    always_comb begin
        win = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (sensor[i]) win = CH_W'(i);
        end
    end

    assign none = ~|sensor;

    always_comb begin
        state_nx   = state;
        cand_nx    = cand;
        dbc_nx     = dbc;
        hold_nx    = hold_cnt;
        buzzer_nx  = buzzer;
        latched_nx = latched;
        hit_nx     = clr_hits ? '0 : hit;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (!none) begin
                    cand_nx = win;
                    dbc_nx  = DBC_W'(1);
                    if (DEBOUNCE == 1) fire = 1'b1;
                    else               state_nx = QUAL;
                end
            end
            QUAL: begin
                if (none) begin
                    state_nx = IDLE;
                    dbc_nx   = '0;
                end else if (win != cand) begin
                    cand_nx = win;
                    dbc_nx  = DBC_W'(1);
                end else begin
                    dbc_nx = dbc + DBC_W'(1);
                    if (dbc_nx == DBC_MAX) fire = 1'b1;
                end
            end
            ALARM: begin
                // Sensors are ignored here; ack beats hold expiry.
                if (ack || (hold_cnt == HOLD_MAX && !latched)) begin
                    state_nx  = IDLE;
                    buzzer_nx = '0;
                    dbc_nx    = '0;
                    hold_nx   = '0;
                end else if (hold_cnt < HOLD_MAX) begin
                    hold_nx = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        // Alarm entry; the hit set wins over a simultaneous clr_hits.
        if (fire) begin
            state_nx        = ALARM;
            buzzer_nx       = onehot(cand_nx);
            hold_nx         = HOLD_W'(1);
            latched_nx      = latch_mode;
            hit_nx[cand_nx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cand     <= '0;
            dbc      <= '0;
            hold_cnt <= '0;
            buzzer   <= '0;
            hit      <= '0;
            latched  <= 1'b0;
        end else if (en) begin
            state    <= state_nx;
            cand     <= cand_nx;
            dbc      <= dbc_nx;
            hold_cnt <= hold_nx;
            buzzer   <= buzzer_nx;
            hit      <= hit_nx;
            latched  <= latched_nx;
        end
    end

    assign alarm_ch = cand;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// Bench for sensor_alarm_ctrl: directed scenarios plus random traffic, every edge
// compared against an integer run-length / on-time reference model.
module tb_sensor_alarm_ctrl;

    localparam int N_CH     = 4;
    localparam int DEBOUNCE = 7;
    localparam int HOLD     = 31;

    logic       clk = 1'b0;
    logic       rst, en, latch_mode, ack, clr_hits;
    logic [3:0] sensor;
    logic [3:0] buzzer, hit;
    logic [1:0] alarm_ch;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: length of the current same-winner run, and how many
    // cycles the buzzer has been on (0 = no alarm).
    int         m_run = 0;
    int         m_ch  = 0;
    int         m_on  = 0;
    bit         m_lat = 0;
    logic [3:0] m_hit = '0;

    sensor_alarm_ctrl #(.N_CH(N_CH), .DEBOUNCE(DEBOUNCE), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .en(en), .sensor(sensor), .latch_mode(latch_mode),
        .ack(ack), .clr_hits(clr_hits), .buzzer(buzzer), .alarm_ch(alarm_ch),
        .busy(busy), .hit(hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [3:0] s,
                              input logic la, input logic a, input logic c);
        int w;
        bit fired;
        fired = 0;
        if (r) begin
            m_run = 0; m_ch = 0; m_on = 0; m_lat = 0; m_hit = '0;
            return;
        end
        if (!e) return;
        if (m_on > 0) begin
            if (a)                m_on = 0;
            else if (m_on < HOLD) m_on++;
            else if (!m_lat)      m_on = 0;
            if (m_on == 0) m_run = 0;
        end else begin
            w = -1;
            for (int i = N_CH - 1; i >= 0; i--) if (s[i]) w = i;
            if (w < 0) m_run = 0;
            else if (m_run > 0 && w == m_ch) m_run++;
            else begin m_ch = w; m_run = 1; end
            if (m_run == DEBOUNCE) begin fired = 1; m_on = 1; m_lat = la; end
        end
        if (c) m_hit = '0;
        if (fired) m_hit[m_ch] = 1'b1;
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] s,
                        input logic la, input logic a, input logic c);
        logic [3:0] eb;
        rst = r; en = e; sensor = s; latch_mode = la; ack = a; clr_hits = c;
        @(posedge clk);
        #1;
        model_edge(r, e, s, la, a, c);
        eb = (m_on > 0) ? (4'b0001 << m_ch) : 4'b0000;
        chk("buzzer", buzzer, eb);
        chk("alarm_ch", alarm_ch, m_ch);
        chk("busy", busy, (m_on > 0 || m_run > 0));
        chk("hit", hit, m_hit);
    endtask

    initial begin
        int first_on, hi, refire;
        bit prev;
        logic [3:0] pat;
        int dur;
        logic la;

        // Reset, including reset while disabled.
        step(1, 1, 4'b1111, 0, 0, 0);
        step(1, 0, 4'b0000, 0, 0, 0);
        chk("reset_buzzer", buzzer, 4'b0000);
        chk("reset_busy", busy, 1'b0);
        step(0, 1, 4'b0000, 0, 0, 0);

        // Held sensor 2: fire on 7th edge, 31 cycles on, re-fire 7 after IDLE.
        first_on = 0; hi = 0; refire = 0; prev = 0;
        for (int i = 1; i <= 50; i++) begin
            step(0, 1, 4'b0100, 0, 0, 0);
            if (buzzer != 0) begin
                if (first_on == 0) first_on = i;
                else if (refire == 0 && !prev) refire = i;
                if (refire == 0) hi++;
            end
            prev = (buzzer != 0);
        end
        chk("first_on_edge", first_on, 7);
        chk("hold_len", hi, 31);
        chk("refire_edge", refire, 45);
        chk("s1_alarm_ch", alarm_ch, 2);
        chk("s1_hit", hit, 4'b0100);
        step(0, 1, 4'b0000, 0, 1, 1);

        // Short pulse on sensor 1 never fires.
        for (int i = 0; i < 6; i++) step(0, 1, 4'b0010, 0, 0, 0);
        step(0, 1, 4'b0000, 0, 0, 0);
        chk("short_busy", busy, 1'b0);
        chk("short_hit", hit, 4'b0000);

        // Higher-priority channel restarts qualification.
        for (int i = 0; i < 3; i++) step(0, 1, 4'b1000, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 4'b1001, 0, 0, 0);
        chk("switch_pre", buzzer, 4'b0000);
        step(0, 1, 4'b1001, 0, 0, 0);
        chk("switch_buzzer", buzzer, 4'b0001);
        chk("switch_hit3", hit[3], 1'b0);
        step(0, 1, 4'b0000, 0, 1, 0);

        // Latched mode holds past HOLD until ack; latch_mode only sampled on entry.
        for (int i = 0; i < 7; i++) step(0, 1, 4'b0001, 1, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 1, 4'b0000, 0, 0, 0);
        chk("latched_on", buzzer, 4'b0001);
        step(0, 1, 4'b0000, 0, 1, 0);
        chk("latched_ack", buzzer, 4'b0000);

        // Early ack in non-latched mode.
        for (int i = 0; i < 7; i++) step(0, 1, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 4'b0000, 0, 0, 0);
        step(0, 1, 4'b0000, 0, 1, 0);
        chk("early_ack", buzzer, 4'b0000);

        // Enable low for 5 cycles mid-alarm stretches the on-time.
        hi = 0;
        for (int i = 1; i <= 60; i++) begin
            step(0, !(i >= 10 && i <= 14), (i <= 7) ? 4'b0100 : 4'b0000, 0, 0, 0);
            if (buzzer != 0) hi++;
        end
        chk("en_freeze_len", hi, 36);

        // Reset while disabled, mid-alarm.
        for (int i = 0; i < 12; i++) step(0, 1, (i < 7) ? 4'b0100 : 4'b0000, 0, 0, 0);
        step(1, 0, 4'b0100, 0, 0, 0);
        chk("rst_buzzer", buzzer, 4'b0000);
        chk("rst_hit", hit, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alarm_ch", alarm_ch, 2'd0);

        // clr_hits on the firing edge keeps only the new bit.
        for (int i = 0; i < 7; i++) step(0, 1, 4'b0010, 0, 0, 0);
        step(0, 1, 4'b0000, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 4'b1000, 0, 0, 0);
        step(0, 1, 4'b1000, 0, 0, 1);
        chk("clr_same_edge", hit, 4'b1000);
        step(0, 1, 4'b0000, 0, 1, 0);

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            pat = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) pat = 4'b0000;
            dur = $urandom_range(1, 20);
            la  = 1'($urandom_range(0, 1));
            for (int j = 0; j < dur; j++)
                step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, pat, la,
                     $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
